cache_line_writeback: RTL
=========================

// Module: cache_line_writeback
// PURPOSE
//   Write-back engine for the data cache: takes one evicted dirty cache line and writes it to BurstRAM.
//   A write burst carries RAM_BURST_DATA_COUNT words, and only dirty bytes are written.
//   Counterpart of the cache's line-fill read path.
//   Sits between the cache controller (start/busy/done) and the BurstRAM command/write-data ports.
// PARAMETERS
//   RAM_DEPTH_BITWIDTH       4   width of BurstRAM word address
//   RAM_BURST_DATA_BITWIDTH  64  bits per burst word
//   RAM_BURST_DATA_COUNT     4   words per burst; line = COUNT*BITWIDTH bits (256 = 32 B)
// PORTS
//   clk            in   1      clock, all logic on rising edge
//   rst            in   1      synchronous, active-high reset
//   start          in   1      request write-back; sampled only while busy=0
//   line_addr      in   RAM_DEPTH_BITWIDTH  BurstRAM word address of line; low log2(COUNT) bits ignored (forced 0)
//   line_data      in   COUNT*BITWIDTH      line contents; word k = line_data[k*BITWIDTH +: BITWIDTH]
//   line_dirty     in   COUNT*BITWIDTH/8    byte-dirty flags; 1 = byte must be written
//   busy           out  1      high from cycle after accepted start until done
//   done           out  1      one-cycle pulse: write-back complete
//   br_cmd         out  1      BurstRAM command, 1 = write, 0 = read
//   br_cmd_en      out  1      one-cycle command strobe
//   br_addr        out  RAM_DEPTH_BITWIDTH  burst start address
//   br_wr_data     out  RAM_BURST_DATA_BITWIDTH  write word
//   br_data_mask   out  BITWIDTH/8  1 = byte NOT written
//   br_busy        in   1      BurstRAM cannot accept a command
// BEHAVIOUR
//   - Clocking and reset: single clock clk. rst is synchronous and active-high.
//   - All outputs are registered.
//   - Reset values: busy=0, done=0, br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0, br_data_mask=all 1s.
//   - Start acceptance: start sampled at cycle 0 with busy=0.
//     - At that edge, latch line_addr (aligned), line_data and line_dirty. Later input changes are ignored.
//     - start while busy=1 is ignored, not queued.
//   - FSM IDLE: accept start.
//     - If line_dirty==0: go to DONE (no RAM command).
//     - Otherwise: go to WAIT.
//   - FSM WAIT: each cycle sample br_busy. When br_busy=0, next cycle drive br_cmd_en=1, br_cmd=1, br_addr, word0 and mask0; go to BURST.
//   - FSM BURST: words 1..COUNT-1 on consecutive cycles, no gaps.
//     - br_cmd_en is high only on the word0 cycle.
//     - br_busy is ignored once the command has issued.
//     - br_data_mask for word k = ~line_dirty[k*BITWIDTH/8 +: BITWIDTH/8].
//     - After the last word: go to DONE.
//   - FSM DONE: done=1 and busy=0 in the same cycle; return to IDLE. A new start is accepted in the DONE cycle.
//   - Outside a burst: br_wr_data=0, br_data_mask=all 1s, br_cmd_en=0, br_cmd=0.
//   - Latency with br_busy=0, default COUNT=4:
//     - start@0, busy@1, cmd_en+word0@2, words1-3@3-5, done@6.
//     - Clean line (line_dirty==0): done@1.
//   - rst mid-operation: within one edge all outputs return to reset values and state goes to IDLE; the partial burst is abandoned.
//     - BurstRAM shares rst, so no dangling RAM state.
//   - Single-master: the RAM arbiter above guarantees no other initiator issues commands while busy=1.
// TESTING (BurstRAM: DEPTH_BITWIDTH=4, CYCLES_BEFORE_DATA_READY=3, BURST_COUNT=4, RAM.mem preload)
//   1. Full line: line_addr=4, all dirty, words 64'h1111..11/2222..22/3333..33/4444..44, br_busy=0
//      -> cmd_en only @2, done @6; BurstRAM read of addr 4 returns the 4 words in order.
//   2. Partial: line_addr=0, line_dirty=32'h0000_0002, line_data word0=64'h0000_0000_1234_5678
//      -> br_data_mask word0=8'hFD, words1-3=8'hFF; RAM word0 byte1=8'h56, all other bytes keep preload.
//   3. Clean line: line_dirty=0 -> br_cmd_en never high, done @1, RAM unchanged.
//   4. br_busy held high 5 cycles after start -> busy stays high and cmd_en issues 1 cycle after br_busy falls.
//      Words contiguous; RAM contents as in test 1.
//   5. Second start pulsed at cycle 3 of a burst -> ignored: exactly one cmd_en, one done.
//      Start pulsed in the DONE cycle -> accepted.
//   6. rst asserted the cycle word1 is driven -> next cycle all outputs at reset values.
//      A fresh start after rst completes as in test 1.

Source files
------------

// File: rtl/cache_line_writeback.sv
// Write-back engine: copies one evicted dirty cache line into BurstRAM as a
// single write burst, masking out bytes that are not dirty.
//
// Handshakes:
//   cache side : start is taken only while busy=0 (including the done cycle);
//                busy rises the cycle after acceptance and stays high until
//                the one-cycle done pulse, during which busy is already 0.
//   RAM side   : the command is issued (br_cmd_en for one cycle, together
//                with word 0) only after br_busy was seen low. The remaining
//                words follow back-to-back and br_busy is not consulted again.
module cache_line_writeback #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      start,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]                             line_addr,
    input  logic [RAM_BURST_DATA_COUNT*RAM_BURST_DATA_BITWIDTH-1:0]   line_data,
    input  logic [RAM_BURST_DATA_COUNT*RAM_BURST_DATA_BITWIDTH/8-1:0] line_dirty,
    output logic                                                      busy,
    output logic                                                      done,
    output logic                                                      br_cmd,
    output logic                                                      br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]                             br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]                        br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]                      br_data_mask,
    input  logic                                                      br_busy,
    output logic [1:0]                                                dbg_state
);

    localparam int AW  = RAM_DEPTH_BITWIDTH;
    localparam int DW  = RAM_BURST_DATA_BITWIDTH;
    localparam int CNT = RAM_BURST_DATA_COUNT;
    localparam int BW  = DW / 8;
    localparam int LW  = CNT * DW;
    localparam int MW  = LW / 8;
    localparam int CW  = (CNT > 1) ? $clog2(CNT) : 1;

    // Lines are burst-aligned: the low log2(COUNT) address bits are dropped.
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(CNT - 1);
    localparam logic [CW-1:0] LAST_WORD  = CW'(CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;       // index of the word currently on br_wr_data
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   data_q, data_d;
    logic [MW-1:0]   dirty_q, dirty_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cmd_q, cmd_d;
    logic            cmd_en_q, cmd_en_d;
    logic [AW-1:0]   br_addr_q, br_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [BW-1:0]   mask_q, mask_d;
    logic [CW-1:0]   word_sel;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        dirty_d   = dirty_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cmd_d     = 1'b0;
        cmd_en_d  = 1'b0;
        br_addr_d = '0;
        wr_data_d = '0;
        mask_d    = '1;
        word_sel  = (state_q == S_BURST) ? cnt_q + CW'(1) : '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    addr_d  = line_addr & ALIGN_MASK;
                    data_d  = line_data;
                    dirty_d = line_dirty;
                    if (line_dirty == '0) begin
                        // Nothing to write: report completion without a RAM command.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (!br_busy) begin
                    state_d   = S_BURST;
                    cnt_d     = '0;
                    cmd_en_d  = 1'b1;
                    cmd_d     = 1'b1;
                    br_addr_d = addr_q;
                    wr_data_d = data_q[int'(word_sel)*DW +: DW];
                    mask_d    = ~dirty_q[int'(word_sel)*BW +: BW];
                end
            end
            S_BURST: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    busy_d    = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    cmd_d     = 1'b1;
                    br_addr_d = addr_q;
                    wr_data_d = data_q[int'(word_sel)*DW +: DW];
                    mask_d    = ~dirty_q[int'(word_sel)*BW +: BW];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            dirty_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_q     <= 1'b0;
            cmd_en_q  <= 1'b0;
            br_addr_q <= '0;
            wr_data_q <= '0;
            mask_q    <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dirty_q   <= dirty_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmd_q     <= cmd_d;
            cmd_en_q  <= cmd_en_d;
            br_addr_q <= br_addr_d;
            wr_data_q <= wr_data_d;
            mask_q    <= mask_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign br_cmd       = cmd_q;
    assign br_cmd_en    = cmd_en_q;
    assign br_addr      = br_addr_q;
    assign br_wr_data   = wr_data_q;
    assign br_data_mask = mask_q;
    assign dbg_state    = state_q;

endmodule
